sd_spi_master: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 24 ++
 rtl/sd_spi_master.sv | 156 +++++++++++++++
 tb/tb_sd_spi_master.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI mode-0 byte initiator.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  localparam int SLOW_HALF_DEF = 70;
  localparam int FAST_HALF_DEF = 2;

  localparam logic MOSI_IDLE = 1'b1;

  // Divider width; never below one bit so a half-period of 1 still has a counter.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte initiator for the SD port: one byte MSB-first per start,
// with chip-select writes deferred to byte boundaries.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int SLOW_HALF = SLOW_HALF_DEF,
  parameter int FAST_HALF = FAST_HALF_DEF
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_we,
  input  logic       cs_val,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n
);

  localparam int CNT_W = cnt_width(SLOW_HALF, FAST_HALF);
  localparam logic [CNT_W-1:0] SLOW_RLD = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_RLD = CNT_W'(FAST_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  spi_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] rld, rld_nxt;
  logic [CNT_W-1:0] rld_sel;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [7:0]       tx_sh, tx_sh_nxt;
  logic [7:0]       rx_sh, rx_sh_nxt;
  logic [7:0]       rx_data_nxt;
  logic             sck_nxt, mosi_nxt, ss_n_nxt, busy_nxt, done_nxt;
  logic             cs_pend, cs_pend_nxt, cs_pend_vld, cs_pend_vld_nxt;
  logic             load;

  assign rld_sel = fast ? FAST_RLD : SLOW_RLD;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rld         <= '0;
      bitcnt      <= 3'd0;
      tx_sh       <= 8'h00;
      rx_sh       <= 8'h00;
      rx_data     <= 8'hFF;
      sck         <= 1'b0;
      mosi        <= MOSI_IDLE;
      ss_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cs_pend     <= 1'b0;
      cs_pend_vld <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rld         <= rld_nxt;
      bitcnt      <= bitcnt_nxt;
      tx_sh       <= tx_sh_nxt;
      rx_sh       <= rx_sh_nxt;
      rx_data     <= rx_data_nxt;
      sck         <= sck_nxt;
      mosi        <= mosi_nxt;
      ss_n        <= ss_n_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      cs_pend     <= cs_pend_nxt;
      cs_pend_vld <= cs_pend_vld_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rld_nxt         = rld;
    bitcnt_nxt      = bitcnt;
    tx_sh_nxt       = tx_sh;
    rx_sh_nxt       = rx_sh;
    rx_data_nxt     = rx_data;
    sck_nxt         = sck;
    mosi_nxt        = mosi;
    ss_n_nxt        = ss_n;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    cs_pend_nxt     = cs_pend;
    cs_pend_vld_nxt = cs_pend_vld;
    load            = 1'b0;

    // Chip-select writes go straight out when idle, otherwise wait for the byte end.
    if (cs_we) begin
      if (state == IDLE) begin
        ss_n_nxt = cs_val;
      end else begin
        cs_pend_nxt     = cs_val;
        cs_pend_vld_nxt = 1'b1;
      end
    end

    case (state)
      IDLE: load = start;
      LOW: begin
        if (cnt == '0) begin
          sck_nxt   = 1'b1;
          rx_sh_nxt = {rx_sh[6:0], miso};
          cnt_nxt   = rld;
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          sck_nxt = 1'b0;
          if (bitcnt == 3'd7) begin
            rx_data_nxt     = rx_sh;
            done_nxt        = 1'b1;
            busy_nxt        = 1'b0;
            mosi_nxt        = MOSI_IDLE;
            state_nxt       = IDLE;
            if (cs_we)            ss_n_nxt = cs_val;
            else if (cs_pend_vld) ss_n_nxt = cs_pend;
            cs_pend_vld_nxt = 1'b0;
            // A start present on the final edge chains the next byte with no gap.
            load            = start;
          end else begin
            bitcnt_nxt = bitcnt + 3'd1;
            mosi_nxt   = tx_sh[6];
            tx_sh_nxt  = {tx_sh[6:0], 1'b0};
            cnt_nxt    = rld;
            state_nxt  = LOW;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      rld_nxt    = rld_sel;
      cnt_nxt    = rld_sel;
      tx_sh_nxt  = tx_data;
      mosi_nxt   = tx_data[7];
      bitcnt_nxt = 3'd0;
      busy_nxt   = 1'b1;
      state_nxt  = LOW;
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Randomized self-checking bench for sd_spi_master against a bit-timing model.
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, fast = 1'b1, cs_we = 1'b0, cs_val = 1'b1, miso = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, sck, mosi, ss_n;
  logic [7:0] rx_data;

  logic       b_start = 1'b0, b_fast = 1'b1, b_cs_we = 1'b0, b_cs_val = 1'b1, b_miso = 1'b0;
  logic [7:0] b_tx = 8'h00;
  logic       b_busy, b_done, b_sck, b_mosi, b_ss_n;
  logic [7:0] b_rx;

  int n_chk  = 0;
  int n_pass = 0;
  bit ss_model = 1'b1;

  always #5 clk_sys = ~clk_sys;

  sd_spi_master #(.SLOW_HALF(70), .FAST_HALF(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .tx_data(tx_data),
    .fast(fast), .cs_we(cs_we), .cs_val(cs_val), .busy(busy), .done(done),
    .rx_data(rx_data), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  sd_spi_master #(.SLOW_HALF(4), .FAST_HALF(1)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(b_start), .tx_data(b_tx),
    .fast(b_fast), .cs_we(b_cs_we), .cs_val(b_cs_val), .busy(b_busy), .done(b_done),
    .rx_data(b_rx), .sck(b_sck), .mosi(b_mosi), .miso(b_miso), .ss_n(b_ss_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One byte on the main instance. Chip-select events: t=-1 with the start,
  // t>=0 issued after edge E0+t (so taking effect mid-byte), t=-2 none.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] slv, input bit f,
                      input int ta, input bit va, input int tb, input bit vb,
                      input bit poke);
    int h, rises, done_t, ndone;
    bit prev, fall, rise, tim_ok, mosi_ok, ss_ok, mosi_prev, ss0, ss_fin, ss_at;
    bit busy_at, mosi_at;
    logic [7:0] mbits, rx_at;
    h = f ? 2 : 70;
    rises = 0; done_t = -1; ndone = 0; prev = 1'b0;
    tim_ok = 1'b1; mosi_ok = 1'b1; ss_ok = 1'b1; ss_at = 1'b0;
    busy_at = 1'b1; mosi_at = 1'b0; mbits = 8'h00; rx_at = 8'h00;
    ss0 = ss_model;
    if (ta == -1) ss0 = va;
    if (tb == -1) ss0 = vb;
    ss_fin = ss0;
    if (ta >= 0) ss_fin = va;
    if (tb >= 0) ss_fin = vb;

    @(negedge clk_sys);
    mosi_prev = mosi;
    tx_data = tx; fast = f; start = 1'b1; miso = slv[7];
    if (ta == -1) begin cs_we = 1'b1; cs_val = va; end
    for (int t = 0; t <= 16 * h + 2; t++) begin
      @(negedge clk_sys);
      start = 1'b0; cs_we = 1'b0; tx_data = tx;
      if (t == 6 * h) fast = ~f;
      if (poke && t == 6 * h) begin start = 1'b1; tx_data = ~tx; end
      if (t == ta) begin cs_we = 1'b1; cs_val = va; end
      if (t == tb) begin cs_we = 1'b1; cs_val = vb; end
      rise = sck && !prev;
      fall = !sck && prev;
      if (rise) begin
        rises++;
        mbits = {mbits[6:0], mosi};
        if (t != (2 * rises - 1) * h) tim_ok = 1'b0;
        if (rises < 8) miso = slv[7 - rises];
      end
      if (fall && t != 2 * rises * h) tim_ok = 1'b0;
      if (t == 0 && mosi !== tx[7]) mosi_ok = 1'b0;
      if (t > 0 && mosi !== mosi_prev && !fall) mosi_ok = 1'b0;
      if (done) begin
        ndone++;
        if (done_t < 0) begin
          done_t = t; rx_at = rx_data; busy_at = busy; mosi_at = mosi;
        end
      end
      if (t < 16 * h && ss_n !== ss0) ss_ok = 1'b0;
      if (t == 16 * h) ss_at = ss_n;
      prev = sck;
      mosi_prev = mosi;
    end
    fast = f;
    check("sck_rises", rises, 8);
    check("mosi_bits", mbits, tx);
    check("sck_timing", tim_ok, 1);
    check("mosi_on_fall", mosi_ok, 1);
    check("done_time", done_t, 16 * h);
    check("done_count", ndone, 1);
    check("rx_data", rx_at, slv);
    check("busy_at_done", busy_at, 0);
    check("mosi_idle", mosi_at, 1);
    check("ss_during", ss_ok, 1);
    check("ss_after", ss_at, ss_fin);
    ss_model = ss_fin;
  endtask

  task automatic cs_idle(input bit v);
    @(negedge clk_sys);
    cs_we = 1'b1; cs_val = v;
    @(negedge clk_sys);
    cs_we = 1'b0;
    check("cs_idle", ss_n, v);
    ss_model = v;
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk_sys);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 1);
    check("rst_ss", ss_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 8'hFF);
    reset_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (done) nd++;
    end
    check("idle_no_done", nd, 0);
    check("idle_rx", rx_data, 8'hFF);
    check("idle_ss", ss_n, 1);

    xfer(8'hA5, 8'h3C, 1'b1, -2, 1'b0, -2, 1'b0, 1'b0);
    xfer(8'hFF, 8'h00, 1'b0, -2, 1'b0, -2, 1'b0, 1'b0);
    // cs 0 written during the third bit, then 0-then-1 while busy
    xfer(8'h5A, 8'hC3, 1'b1, 10, 1'b0, -2, 1'b0, 1'b0);
    xfer(8'h81, 8'h7E, 1'b1, 6, 1'b0, 14, 1'b1, 1'b0);
    cs_idle(1'b0);
    cs_idle(1'b1);
    // cs together with start, and a start poked mid-byte
    xfer(8'h3C, 8'h96, 1'b1, -1, 1'b0, -2, 1'b0, 1'b1);
    cs_idle(1'b1);
    for (int i = 0; i < 6; i++)
      xfer(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), -2, 1'b0, -2, 1'b0,
           1'($urandom_range(0, 1)));

    // asynchronous reset mid-byte while sck is high and ss_n is low
    cs_idle(1'b0);
    @(negedge clk_sys);
    tx_data = 8'hAA; fast = 1'b1; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("pre_rst_sck", sck, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sck", sck, 0);
    check("mid_rst_ss", ss_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mosi", mosi, 1);
    check("mid_rst_rx", rx_data, 8'hFF);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    ss_model = 1'b1;
    xfer(8'hC6, 8'h5D, 1'b1, -2, 1'b0, -2, 1'b0, 1'b0);

    // back-to-back bytes on the half-period-1 instance
    begin
      int brises, d1, d2, ndb, rise9;
      bit bprev, m_at_d1;
      logic [15:0] bbits;
      brises = 0; d1 = -1; d2 = -1; ndb = 0; rise9 = -1; bprev = 1'b0;
      m_at_d1 = 1'b1; bbits = 16'h0000;
      @(negedge clk_sys);
      b_tx = 8'h01; b_fast = 1'b1; b_start = 1'b1;
      for (int t = 0; t <= 40; t++) begin
        @(negedge clk_sys);
        if (t == 0) b_tx = 8'h02;
        if (b_sck && !bprev) begin
          brises++;
          bbits = {bbits[14:0], b_mosi};
          if (brises == 9) rise9 = t;
        end
        if (b_done) begin
          ndb++;
          if (ndb == 1) begin d1 = t; m_at_d1 = b_mosi; b_start = 1'b0; end
          if (ndb == 2) d2 = t;
        end
        bprev = b_sck;
      end
      check("b2b_done1", d1, 16);
      check("b2b_rise_gap", rise9, d1 + 1);
      check("b2b_mosi_hold", m_at_d1, 0);
      check("b2b_bits", bbits, 16'h0102);
      check("b2b_done2", d2, 32);
      check("b2b_count", ndb, 2);
      check("b2b_rx", b_rx, 8'h00);
      check("b2b_busy_end", b_busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
